// File: rtl/mem_bank_read_sweeper.sv
// Read-side sweeper for a banked memory: one read per (bank, addr) slot per start, with the
// returned data re-tagged after the memory latency. Define MEM_SWEEP_OVERRUN_CNT_EN for overrun_cnt.
module mem_bank_read_sweeper #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 18,
    parameter int unsigned NUM_BANKS    = 2,
    parameter int unsigned BANK_WIDTH   = $clog2(NUM_BANKS),
    parameter int unsigned OUTPUT_DELAY = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     reb,
    output logic [BANK_WIDTH-1:0]    bankb,
    output logic [$clog2(DEPTH)-1:0] addrb,
    input  logic [DATA_WIDTH-1:0]    dob,
    output logic                     out_valid,
    output logic [BANK_WIDTH-1:0]    out_bank,
    output logic [$clog2(DEPTH)-1:0] out_addr,
    output logic [DATA_WIDTH-1:0]    out_data,
`ifdef MEM_SWEEP_OVERRUN_CNT_EN
    output logic                     out_last,
    output logic [7:0]               overrun_cnt
`else
    output logic                     out_last
`endif
);

    localparam int unsigned AddrWidth = $clog2(DEPTH);
    localparam int unsigned TagWidth  = 2 + BANK_WIDTH + AddrWidth;

    localparam logic [BANK_WIDTH-1:0] LastBank  = BANK_WIDTH'(NUM_BANKS - 1);
    localparam logic [AddrWidth-1:0]  LastAddr  = AddrWidth'(DEPTH - 1);
    localparam logic [1:0]            DrainInit = 2'(OUTPUT_DELAY > 0 ? OUTPUT_DELAY - 1 : 0);
    localparam logic                  OneSlot   = (NUM_BANKS == 1) && (DEPTH == 1);

    typedef enum logic [1:0] {StIdle, StSweep, StDrain} state_e;

    state_e                  state_q;
    logic                    rd_last_q;
    logic [1:0]              drain_cnt_q;
    logic [BANK_WIDTH-1:0]   next_bank;
    logic [AddrWidth-1:0]    next_addr;
    logic [TagWidth-1:0]     tag_in;
    logic [TagWidth-1:0]     tag_out;

    always_comb begin
        next_bank = bankb;
        next_addr = addrb + AddrWidth'(1);
        if (addrb == LastAddr) begin
            next_addr = '0;
            next_bank = bankb + BANK_WIDTH'(1);
        end
    end

    // abort shares the reset path: it kills the sweep and suppresses done.
    always_ff @(posedge clk) begin
        if (!reset_n || abort) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b0;
            reb         <= 1'b0;
            bankb       <= '0;
            addrb       <= '0;
            rd_last_q   <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StSweep;
                        busy      <= 1'b1;
                        reb       <= 1'b1;
                        rd_last_q <= OneSlot;
                    end
                end
                StSweep: begin
                    if (rd_last_q) begin
                        reb       <= 1'b0;
                        bankb     <= '0;
                        addrb     <= '0;
                        rd_last_q <= 1'b0;
                        if (OUTPUT_DELAY == 0) begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_q     <= StDrain;
                            drain_cnt_q <= DrainInit;
                        end
                    end else begin
                        bankb     <= next_bank;
                        addrb     <= next_addr;
                        rd_last_q <= (next_bank == LastBank) && (next_addr == LastAddr);
                    end
                end
                StDrain: begin
                    if (drain_cnt_q == 2'd0) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - 2'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef MEM_SWEEP_OVERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overrun_cnt <= '0;
        end else if (start && busy && (overrun_cnt != 8'hff)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

    assign tag_in = {reb, rd_last_q, bankb, addrb};

    // Tags follow the read through the same latency as the memory's data path.
    generate
        if (OUTPUT_DELAY == 0) begin : g_no_delay
            assign tag_out = tag_in;
        end else begin : g_delay
            logic [TagWidth-1:0] pipe_q [OUTPUT_DELAY];

            always_ff @(posedge clk) begin
                if (!reset_n || abort) begin
                    for (int unsigned i = 0; i < OUTPUT_DELAY; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= tag_in;
                    for (int unsigned i = 1; i < OUTPUT_DELAY; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign tag_out = pipe_q[OUTPUT_DELAY-1];
        end
    endgenerate

    assign out_valid = tag_out[TagWidth-1];
    assign out_last  = tag_out[TagWidth-2];
    assign out_bank  = tag_out[AddrWidth +: BANK_WIDTH];
    assign out_addr  = tag_out[AddrWidth-1:0];
    // Gated so stale memory data never leaks out while the stream is idle.
    assign out_data  = out_valid ? dob : '0;

endmodule

// File: doc/mem_bank_read_sweeper.md
Name: mem_bank_read_sweeper

Overview:
Read-side sequencer that sits directly downstream of the banked operator/channel memory.
- On a start pulse it sweeps every (bank, address) slot once by driving the memory's read port (reb, bankb, addrb).
- It realigns the returned dob with bank/address tags delayed to match the memory's OUTPUT_DELAY.
- The result is a tagged, valid-qualified stream for the next stage in the sample-generation pipeline (e.g. an operator or envelope stage).
- It completes one sample-period sweep per start pulse.

Parameters:
- DATA_WIDTH, 8, width of the memory word received on dob and forwarded on out_data.
- DEPTH, 18, words per bank; addrb width is $clog2(DEPTH).
- NUM_BANKS, 2, number of banks swept; bankb width is BANK_WIDTH.
- BANK_WIDTH, $clog2(NUM_BANKS), derived; must not be overridden.
- OUTPUT_DELAY, 1, read latency of the attached memory in cycles: 0, 1 or 2. This value must equal the memory's own setting.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin a sweep.
- abort  in  1  synchronous cancel of the sweep in progress.
- busy  out  1  sweep or drain in progress.
- done  out  1  one-cycle pulse when a sweep completes normally.
- reb  out  1  memory read enable.
- bankb  out  BANK_WIDTH  memory read bank.
- addrb  out  $clog2(DEPTH)  memory read address.
- dob  in  DATA_WIDTH  memory read data.
- out_valid  out  1  out_data and the tags are valid this cycle.
- out_bank  out  BANK_WIDTH  bank tag aligned to out_data.
- out_addr  out  $clog2(DEPTH)  address tag aligned to out_data.
- out_data  out  DATA_WIDTH  data forwarded from dob.
- out_last  out  1  marks the final word of the sweep.

Behaviour:
- Reset (reset_n=0 at an edge):
  - FSM goes to IDLE.
  - busy, done, reb, out_valid and out_last are 0.
  - bankb, addrb, out_bank and out_addr are 0; the tag pipeline is cleared.
  - Reset applied mid-sweep kills the sweep. No further out_valid and no done are produced.
- FSM states: IDLE, SWEEP, DRAIN.
- IDLE:
  - reb=0 and bankb/addrb are held at 0.
  - start=1 moves the FSM to SWEEP.
  - The first read (bank 0, addr 0, reb=1) is issued in the cycle after start is sampled.
- SWEEP:
  - reb=1 every cycle; exactly one read is issued per cycle.
  - addrb increments each cycle. When addrb reaches DEPTH-1 it wraps to 0 and bankb increments.
  - After the read at (NUM_BANKS-1, DEPTH-1) is issued:
    - if OUTPUT_DELAY>0, the FSM goes to DRAIN;
    - if OUTPUT_DELAY=0, the FSM goes directly to IDLE.
  - Total reads per sweep = NUM_BANKS*DEPTH. The count never wraps, and no slot is read twice.
- DRAIN:
  - reb=0 and bankb/addrb return to 0.
  - The FSM stays in DRAIN for OUTPUT_DELAY cycles, then goes to IDLE.
- Alignment:
  - reb, bankb, addrb and the last flag pass through an OUTPUT_DELAY-stage shift register to form out_valid, out_bank, out_addr and out_last.
  - out_data is combinational from dob, so it is valid in the same cycle as out_valid. With OUTPUT_DELAY=0 the path from addrb to out_data is purely combinational.
  - When out_valid=0, out_bank, out_addr and out_data are don't-care; out_last=0.
- busy is 1 from the first reb cycle through the cycle carrying out_last, inclusive.
- done:
  - A one-cycle pulse in the cycle after out_last.
  - busy is 0 in the done cycle.
  - start is accepted in the done cycle.
- Simultaneous events:
  - start while busy=1 is ignored.
  - abort in any state forces IDLE on the next edge, zeros the valid pipeline, and produces no done.
  - abort has priority over start in the same cycle.
  - start and abort arriving together in IDLE leave the FSM in IDLE.

Optional Feature:
- Macro: MEM_SWEEP_OVERRUN_CNT_EN.
- When defined:
  - adds the output port overrun_cnt [7:0];
  - overrun_cnt increments on each start sampled while busy=1 and saturates at 255;
  - it is cleared only by reset_n.
- When undefined, the port and counter do not exist, and starts while busy are silently dropped.

Test Plan:
- Preload memory with word = {bank,addr}; NUM_BANKS=2, DEPTH=18, OUTPUT_DELAY=2; start at cycle 0.
  - Required: reb in cycles 1..36; out_valid in cycles 3..38, with out_data equal to {out_bank,out_addr}.
  - Required: bank 0 addr 0..17, then bank 1 addr 0..17.
  - Required: out_last in cycle 38 only; done in cycle 39; busy high in cycles 1..38.
- Same setup with OUTPUT_DELAY=0.
  - Required: out_valid in the same cycles as reb (1..36); done in cycle 37; DRAIN never entered.
- Pulse start again at cycle 10 during the sweep.
  - Required: the sweep is unchanged and there is exactly one done.
  - Required, with MEM_SWEEP_OVERRUN_CNT_EN: overrun_cnt=1.
- Assert abort at cycle 20.
  - Required: reb=0 and out_valid=0 from cycle 21 onward; no done.
  - Required: a start at cycle 25 gives a fresh sweep beginning at bank 0, addr 0 in cycle 26.
- Drop reset_n to 0 at cycle 15 for one cycle.
  - Required: all outputs are 0 at cycle 16; no out_valid or done follows until a new start.
- Issue start in the done cycle (cycle 39, OUTPUT_DELAY=2).
  - Required: a back-to-back sweep with reb in cycles 40..75 and done at cycle 78.
